// File: rtl/wb_dest_select_buffer_if.sv
// Write-back destination buffer bus: the upstream push side and the downstream
// pop side, grouped so one modport gives the buffer's view.
interface wb_dest_select_buffer_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int SEL_WIDTH      = 2
);
   logic                      in_valid;
   logic                      in_ready;
   logic [SEL_WIDTH-1:0]      dst_sel;
   logic [REG_ADDR_WIDTH-1:0] rt_i;
   logic [REG_ADDR_WIDTH-1:0] rd_i;
   logic                      reg_write_i;
   logic [DATA_WIDTH-1:0]     result_i;
   logic [DATA_WIDTH-1:0]     link_addr_i;
   logic                      out_valid;
   logic                      out_ready;
   logic                      wb_we;
   logic [REG_ADDR_WIDTH-1:0] wb_addr;
   logic [DATA_WIDTH-1:0]     wb_data;
   logic [1:0]                occupancy;

   // Environment side: drives the EX/MEM push fields and the write-back ready.
   modport master (
      output in_valid, dst_sel, rt_i, rd_i, reg_write_i, result_i, link_addr_i, out_ready,
      input  in_ready, out_valid, wb_we, wb_addr, wb_data, occupancy
   );

   // Buffer side.
   modport slave (
      input  in_valid, dst_sel, rt_i, rd_i, reg_write_i, result_i, link_addr_i, out_ready,
      output in_ready, out_valid, wb_we, wb_addr, wb_data, occupancy
   );
endinterface

// File: rtl/wb_dest_select_buffer.sv
// Write-back destination select (rt / rd / link register) feeding a 2-entry
// skid buffer. Selection happens at push time; outputs come only from registers.
module wb_dest_select_buffer #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int LINK_REG       = 31,
   parameter int SEL_WIDTH      = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   wb_dest_select_buffer_if.slave bus
);
   localparam logic [SEL_WIDTH-1:0]      SEL_RT    = SEL_WIDTH'(0);
   localparam logic [SEL_WIDTH-1:0]      SEL_RD    = SEL_WIDTH'(1);
   localparam logic [SEL_WIDTH-1:0]      SEL_LINK  = SEL_WIDTH'(2);
   localparam logic [REG_ADDR_WIDTH-1:0] LINK_ADDR = REG_ADDR_WIDTH'(LINK_REG);

   logic [DATA_WIDTH-1:0]     r_slot_data [2];
   logic [REG_ADDR_WIDTH-1:0] r_slot_addr [2];
   logic [1:0]                r_slot_we;
   logic                      r_rd_ptr;
   logic                      r_wr_ptr;
   logic [1:0]                r_count;

   logic                      w_push;
   logic                      w_pop;
   logic                      w_in_ready;
   logic                      w_out_valid;
   logic [REG_ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0]     w_sel_data;
   logic                      w_sel_we;

   assign w_in_ready  = (r_count < 2'd2);
   assign w_out_valid = (r_count != 2'd0);
   assign w_push      = bus.in_valid && w_in_ready;
   assign w_pop       = w_out_valid && bus.out_ready;

   // Destination/data selection; any code other than rt/rd/link is "no write"
   // with address 0, which the $zero check then turns into we=0.
   always_comb begin
      w_sel_addr = '0;
      w_sel_data = bus.result_i;
      case (bus.dst_sel)
         SEL_RT:   w_sel_addr = bus.rt_i;
         SEL_RD:   w_sel_addr = bus.rd_i;
         SEL_LINK: begin
            w_sel_addr = LINK_ADDR;
            w_sel_data = bus.link_addr_i;
         end
         default:  w_sel_addr = '0;
      endcase
      w_sel_we = bus.reg_write_i && (w_sel_addr != '0);
   end

   // Slot storage: written on every accepted push; a flushed push is harmless
   // because the count and pointers are cleared in the same cycle.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_slot_data[r_wr_ptr] <= w_sel_data;
         r_slot_addr[r_wr_ptr] <= w_sel_addr;
         r_slot_we[r_wr_ptr]   <= w_sel_we;
      end
   end

   // Occupancy and pointers; reset and flush both empty the buffer and win
   // over any push/pop in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_count  <= 2'd0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.occupancy = r_count;
   assign bus.wb_we     = w_out_valid ? r_slot_we[r_rd_ptr]   : 1'b0;
   assign bus.wb_addr   = w_out_valid ? r_slot_addr[r_rd_ptr] : '0;
   assign bus.wb_data   = w_out_valid ? r_slot_data[r_rd_ptr] : '0;
endmodule

// File: tb/tb_wb_dest_select_buffer.sv
// Bench for wb_dest_select_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_wb_dest_select_buffer;
   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   ent_t q[$];

   wb_dest_select_buffer_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SEL_WIDTH(2)) bus ();

   wb_dest_select_buffer #(
      .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .LINK_REG(31), .SEL_WIDTH(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic ent_t make_entry(logic [1:0] sel, logic [4:0] rt, logic [4:0] rd,
                                       logic rw, logic [31:0] res, logic [31:0] link);
      ent_t e;
      e.addr = (sel == 2'd0) ? rt : (sel == 2'd1) ? rd : (sel == 2'd2) ? 5'd31 : 5'd0;
      e.data = (sel == 2'd2) ? link : res;
      e.we   = rw && (sel != 2'd3) && (e.addr != 5'd0);
      return e;
   endfunction

   // Reference model: a queue of at most two entries, updated at each edge.
   always @(posedge clk) begin
      if (reset || flush) begin
         q.delete();
      end else begin
         bit push;
         bit pop;
         push = bus.in_valid && (q.size() < 2);
         pop  = (q.size() > 0) && bus.out_ready;
         if (pop) void'(q.pop_front());
         if (push) q.push_back(make_entry(bus.dst_sel, bus.rt_i, bus.rd_i,
                                          bus.reg_write_i, bus.result_i, bus.link_addr_i));
      end
   end

   // Compare process: DUT outputs against the model, away from the rising edge.
   always @(negedge clk) begin
      if (chk_en) begin
         ent_t h;
         h = (q.size() > 0) ? q[0] : '0;
         check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
         check("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
         check("occupancy", 32'(bus.occupancy), 32'(q.size()));
         check("wb_we",     32'(bus.wb_we),     32'(h.we));
         check("wb_addr",   32'(bus.wb_addr),   32'(h.addr));
         check("wb_data",   bus.wb_data,        h.data);
      end
   end

   task automatic drv(bit v, int sel, int rt, int rd, bit rw,
                      logic [31:0] res, logic [31:0] link, bit ordy);
      bus.in_valid    = v;
      bus.dst_sel     = 2'(sel);
      bus.rt_i        = 5'(rt);
      bus.rd_i        = 5'(rd);
      bus.reg_write_i = rw;
      bus.result_i    = res;
      bus.link_addr_i = link;
      bus.out_ready   = ordy;
      @(negedge clk);
   endtask

   task automatic idle(bit ordy);
      drv(1'b0, 0, 0, 0, 1'b0, 32'h0, 32'h0, ordy);
   endtask

   initial begin
      int ordy_pct;
      reset = 1'b1;
      flush = 1'b0;
      idle(1'b1);
      chk_en = 1'b1;
      idle(1'b1);
      reset = 1'b0;
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst in_ready",  32'(bus.in_ready),  32'd1);
      check("rst occupancy", 32'(bus.occupancy), 32'd0);
      check("rst wb_data",   bus.wb_data,        32'd0);

      // Single push through an empty buffer
      drv(1'b1, 0, 8, 3, 1'b1, 32'h1234, 32'hdead, 1'b1);
      check("t1 out_valid", 32'(bus.out_valid), 32'd1);
      check("t1 wb_addr",   32'(bus.wb_addr),   32'd8);
      check("t1 wb_data",   bus.wb_data,        32'h1234);
      check("t1 wb_we",     32'(bus.wb_we),     32'd1);
      idle(1'b1);
      check("t1 drained",   32'(bus.out_valid), 32'd0);

      // jal link, then rd=0 suppressed write
      drv(1'b1, 2, 4, 5, 1'b1, 32'h5555, 32'h00400008, 1'b1);
      check("t2 link addr", 32'(bus.wb_addr), 32'd31);
      check("t2 link data", bus.wb_data,      32'h00400008);
      check("t2 link we",   32'(bus.wb_we),   32'd1);
      drv(1'b1, 1, 7, 0, 1'b1, 32'h77, 32'h0, 1'b1);
      check("t2 zero we",    32'(bus.wb_we),     32'd0);
      check("t2 zero valid", 32'(bus.out_valid), 32'd1);
      idle(1'b1);
      check("t2 zero popped", 32'(bus.out_valid), 32'd0);

      // Backpressure: third entry held until a slot frees
      drv(1'b1, 1, 0, 1, 1'b1, 32'h101, 32'h0, 1'b0);
      check("t3 occ1", 32'(bus.occupancy), 32'd1);
      drv(1'b1, 1, 0, 2, 1'b1, 32'h102, 32'h0, 1'b0);
      check("t3 occ2",     32'(bus.occupancy), 32'd2);
      check("t3 in_ready", 32'(bus.in_ready),  32'd0);
      drv(1'b1, 1, 0, 3, 1'b1, 32'h103, 32'h0, 1'b0);
      check("t3 head held", 32'(bus.wb_addr), 32'd1);
      drv(1'b1, 1, 0, 3, 1'b1, 32'h103, 32'h0, 1'b1);
      check("t3 pop2", 32'(bus.wb_addr), 32'd2);
      drv(1'b1, 1, 0, 3, 1'b1, 32'h103, 32'h0, 1'b1);
      check("t3 pop3", 32'(bus.wb_addr), 32'd3);
      idle(1'b1);
      check("t3 drained", 32'(bus.out_valid), 32'd0);

      // Streaming push+pop at occupancy 1, pointers wrap
      for (int r = 4; r <= 7; r++) begin
         drv(1'b1, 1, 0, r, 1'b1, 32'(r), 32'h0, 1'b1);
         check("t4 stream addr", 32'(bus.wb_addr),   32'(r));
         check("t4 stream occ",  32'(bus.occupancy), 32'd1);
      end
      idle(1'b1);

      // Flush with a push attempt in the same cycle
      drv(1'b1, 1, 0, 10, 1'b1, 32'hA, 32'h0, 1'b0);
      drv(1'b1, 1, 0, 11, 1'b1, 32'hB, 32'h0, 1'b0);
      flush = 1'b1;
      drv(1'b1, 1, 0, 12, 1'b1, 32'hC, 32'h0, 1'b0);
      flush = 1'b0;
      check("t5 occ",      32'(bus.occupancy), 32'd0);
      check("t5 valid",    32'(bus.out_valid), 32'd0);
      check("t5 in_ready", 32'(bus.in_ready),  32'd1);
      idle(1'b1);
      check("t5 no ghost", 32'(bus.out_valid), 32'd0);

      // Reset together with flush while full
      drv(1'b1, 1, 0, 20, 1'b1, 32'h14, 32'h0, 1'b0);
      drv(1'b1, 1, 0, 21, 1'b1, 32'h15, 32'h0, 1'b0);
      reset = 1'b1;
      flush = 1'b1;
      drv(1'b1, 1, 0, 22, 1'b1, 32'h16, 32'h0, 1'b0);
      reset = 1'b0;
      flush = 1'b0;
      check("t6 occ",     32'(bus.occupancy), 32'd0);
      check("t6 we",      32'(bus.wb_we),     32'd0);
      check("t6 addr",    32'(bus.wb_addr),   32'd0);
      check("t6 data",    bus.wb_data,        32'd0);
      check("t6 valid",   32'(bus.out_valid), 32'd0);

      // Random traffic; a stalled beat is held stable until accepted
      ordy_pct = 50;
      for (int c = 0; c < 4000; c++) begin
         bit hold;
         if (c % 256 == 0) ordy_pct = $urandom_range(10, 100);
         hold  = bus.in_valid && (q.size() == 2) && !reset && !flush;
         reset = ($urandom_range(0, 399) == 0);
         flush = ($urandom_range(0, 49) == 0);
         bus.out_ready = ($urandom_range(1, 100) <= ordy_pct);
         if (!hold) begin
            bus.in_valid    = ($urandom_range(0, 2) != 0);
            bus.dst_sel     = 2'($urandom_range(0, 3));
            bus.rt_i        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            bus.rd_i        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            bus.reg_write_i = ($urandom_range(0, 4) != 0);
            bus.result_i    = $urandom;
            bus.link_addr_i = $urandom;
         end
         @(negedge clk);
      end
      reset = 1'b0;
      flush = 1'b0;
      idle(1'b1);
      idle(1'b1);
      check("final drained", 32'(bus.out_valid), 32'd0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/wb_dest_select_buffer.md
Name: wb_dest_select_buffer

Overview:
- Parametrised successor to the write-back destination 3:1 mux in the MIPS datapath.
- Selects the destination register number per instruction: rt, rd, or the link register for jal/jalr.
- Selects the matching write-back data: ALU/memory result, or the return address for link instructions.
- Registers the result into a 2-entry elastic (skid) buffer with valid/ready handshake, flush, and $zero write suppression, decoupling the EX/MEM side from write-back.

Parameters:
- DATA_WIDTH, 32, width of write-back data and link address.
- REG_ADDR_WIDTH, 5, width of register numbers.
- LINK_REG, 31, register number written for sel=2 (MIPS $ra).
- SEL_WIDTH, 2, width of dst_sel.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  buffer can accept this cycle.
- dst_sel  input  SEL_WIDTH  0=rt, 1=rd, 2=LINK_REG, 3=no write.
- rt_i  input  REG_ADDR_WIDTH  rt field.
- rd_i  input  REG_ADDR_WIDTH  rd field.
- reg_write_i  input  1  instruction writes the register file.
- result_i  input  DATA_WIDTH  ALU/memory result.
- link_addr_i  input  DATA_WIDTH  return address (PC+8 as supplied).
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- wb_we  output  1  head write enable.
- wb_addr  output  REG_ADDR_WIDTH  head destination register.
- wb_data  output  DATA_WIDTH  head write data.
- occupancy  output  2  entries held (0..2).

Behaviour:
- Clock/reset: single clock clk; reset is synchronous and active-high.
- Reset: count=0, out_valid=0, in_ready=1 from the first cycle after reset; wb_we=0, wb_addr=0, wb_data=0; occupancy=0.
- Selection, computed at push time:
  - sel=0: addr=rt_i, data=result_i.
  - sel=1: addr=rd_i, data=result_i.
  - sel=2: addr=LINK_REG, data=link_addr_i.
  - sel=3: addr=0, data=result_i, we=0.
- Write enable: we = reg_write_i && (sel!=3) && (addr!=0). Suppressed entries are still buffered and popped, so ordering is preserved.
- Handshake:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - in_ready = (count<2). This is a registered-state function, not combinationally dependent on out_ready.
  - out_valid = (count>0).
- Latency: an entry pushed into an empty buffer appears on the outputs the next cycle. There is no combinational in→out path.
- Storage: 2-slot circular buffer with 1-bit rd_ptr and wr_ptr, wrapping 1→0. The outputs show slot[rd_ptr], and are zero when empty.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together (count=1): count unchanged, both pointers advance.
  - At count=2, push is impossible because in_ready=0; a pop frees a slot and in_ready=1 the next cycle.
- Upstream holding rule: while in_valid=1 && in_ready=0, the upstream must hold its inputs stable; the block does not latch them.
- Flush: same effect as reset on count and pointers; flush has priority over a simultaneous push or pop. The flushed-cycle push is dropped, and the next cycle has out_valid=0 and in_ready=1.
- Reset priority: reset overrides flush. Reset mid-stream discards all entries.
- Output holding rule: outputs must not change while out_valid=1 && out_ready=0.

Test Plan:
- Reset, then push sel=0, rt_i=8, result_i=0x1234, reg_write_i=1, out_ready=1 → next cycle out_valid=1, wb_addr=8, wb_data=0x1234, wb_we=1; the cycle after, out_valid=0.
- Push sel=2, link_addr_i=0x00400008 (jal) → wb_addr=31, wb_data=0x00400008, wb_we=1; push sel=1 with rd_i=0 → wb_we=0, entry still popped.
- out_ready=0, push 3 entries (rd=1,2,3) → occupancy=2, in_ready=0, third held. Then out_ready=1 → pops in order 1,2,3 with no loss or duplication.
- occupancy=1, simultaneous push and pop for 4 cycles (rd=4..7) → occupancy stays 1, outputs 4,5,6,7 in order, pointers wrap.
- occupancy=2, assert flush with in_valid=1 → next cycle occupancy=0, out_valid=0, in_ready=1, flushed-cycle entry absent.
- Assert reset and flush together mid-stream with occupancy=2 → all outputs zero next cycle, occupancy=0.
